// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT input frame sequencer.
package fft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } seq_state_t;

    localparam int PRIME_W = 8;

    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

    // Shifts the low 'width' bits out LSB-first so they land reversed.
    function automatic logic [31:0] bitrev(
        input logic [31:0] idx,
        input int          width
    );
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = idx;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r = {r[30:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_frame_sequencer_beat_counter.sv
// Modulo-MOD beat counter with soft clear and wrap pulse.
module fft_beat_counter
    import fft_seq_pkg::*;
#(
    parameter  int MOD = 16,
    localparam int CW  = clog2_min1(MOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          valid,
    output logic [CW-1:0] count,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(MOD - 1);

    assign wrap = valid && (count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (valid) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// FFT input frame sequencer: beat/frame counting, markers, priming FSM.
// Define BITREV_INDEX_EN to add the bit-reversed index output.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter  int NUM          = 16,
    parameter  int PAR          = 1,
    parameter  int PRIME_FRAMES = 1,
    parameter  int FRAME_W      = 8,
    localparam int IDX_W        = $clog2(NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               valid,
    output logic [IDX_W-1:0]   sample_idx,
    output logic               sof,
    output logic               eof,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               bfly_enable,
    output logic [1:0]         state
`ifdef BITREV_INDEX_EN
    ,
    output logic [IDX_W-1:0]   bitrev_idx
`endif
);

    localparam int BEATS = NUM / PAR;
    localparam int BW    = clog2_min1(BEATS);
    localparam int SH    = $clog2(PAR);

    localparam logic [PRIME_W-1:0] PRIME_MAX  = PRIME_W'(PRIME_FRAMES);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_FRAMES - 1);

    logic [BW-1:0]      beat_cnt;
    logic               wrap;
    logic [PRIME_W-1:0] prime_cnt;
    logic               prime_hit;
    seq_state_t         st;

    fft_beat_counter #(
        .MOD (BEATS)
    ) u_beat (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .valid (valid),
        .count (beat_cnt),
        .wrap  (wrap)
    );

    assign sof        = valid && (beat_cnt == '0);
    assign eof        = wrap;
    assign sample_idx = IDX_W'(beat_cnt) << SH;
    assign state      = st;

    // Only the frame that brings prime_cnt up to PRIME_FRAMES can hit.
    assign prime_hit  = wrap && (prime_cnt == PRIME_LAST);

`ifdef BITREV_INDEX_EN
    assign bitrev_idx = IDX_W'(bitrev(32'(sample_idx), IDX_W));
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt   <= '0;
            prime_cnt   <= '0;
            bfly_enable <= 1'b0;
            st          <= IDLE;
        end else if (clr) begin
            frame_cnt   <= '0;
            prime_cnt   <= '0;
            bfly_enable <= 1'b0;
            st          <= IDLE;
        end else if (valid) begin
            if (wrap) begin
                frame_cnt <= frame_cnt + 1'b1;
                if (prime_cnt != PRIME_MAX) begin
                    prime_cnt <= prime_cnt + 1'b1;
                end
            end
            if (prime_hit) begin
                bfly_enable <= 1'b1;
            end
            unique case (st)
                IDLE:    st <= FILL;
                FILL:    st <= prime_hit ? RUN : FILL;
                RUN:     st <= RUN;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Scoreboard bench for fft_frame_sequencer across three configurations.
module tb_fft_frame_sequencer;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clr   = 1'b0;
    logic valid = 1'b0;

    always #5 clk = ~clk;

    // Instances: 0 = NUM16/PAR1/PRIME1, 1 = NUM16/PAR4/PRIME1/FW2,
    // 2 = NUM16/PAR1/PRIME3.
    localparam int NB [3] = '{16, 4, 16};
    localparam int PA [3] = '{1, 4, 1};
    localparam int PR [3] = '{1, 1, 3};
    localparam int FM [3] = '{256, 4, 256};

    logic [3:0] idx_o [3];
    logic       sof_o [3];
    logic       eof_o [3];
    logic       bf_o  [3];
    logic [1:0] st_o  [3];
    logic [3:0] br_o  [3];
    logic [7:0] fc_a;
    logic [1:0] fc_b;
    logic [7:0] fc_c;

    int errors = 0;
    int checks = 0;

    fft_frame_sequencer #(
        .NUM(16), .PAR(1), .PRIME_FRAMES(1), .FRAME_W(8)
    ) u_a (
        .clk(clk), .rst(rst), .clr(clr), .valid(valid),
        .sample_idx(idx_o[0]), .sof(sof_o[0]), .eof(eof_o[0]),
        .frame_cnt(fc_a), .bfly_enable(bf_o[0]), .state(st_o[0])
`ifdef BITREV_INDEX_EN
        , .bitrev_idx(br_o[0])
`endif
    );

    fft_frame_sequencer #(
        .NUM(16), .PAR(4), .PRIME_FRAMES(1), .FRAME_W(2)
    ) u_b (
        .clk(clk), .rst(rst), .clr(clr), .valid(valid),
        .sample_idx(idx_o[1]), .sof(sof_o[1]), .eof(eof_o[1]),
        .frame_cnt(fc_b), .bfly_enable(bf_o[1]), .state(st_o[1])
`ifdef BITREV_INDEX_EN
        , .bitrev_idx(br_o[1])
`endif
    );

    fft_frame_sequencer #(
        .NUM(16), .PAR(1), .PRIME_FRAMES(3), .FRAME_W(8)
    ) u_c (
        .clk(clk), .rst(rst), .clr(clr), .valid(valid),
        .sample_idx(idx_o[2]), .sof(sof_o[2]), .eof(eof_o[2]),
        .frame_cnt(fc_c), .bfly_enable(bf_o[2]), .state(st_o[2])
`ifdef BITREV_INDEX_EN
        , .bitrev_idx(br_o[2])
`endif
    );

`ifndef BITREV_INDEX_EN
    initial for (int i = 0; i < 3; i++) br_o[i] = 4'd0;
`endif

    function automatic int fc_of(input int k);
        if (k == 0) return int'(fc_a);
        if (k == 1) return int'(fc_b);
        return int'(fc_c);
    endfunction

    function automatic int rev4(input int x);
        logic [3:0] v;
        v = 4'(x);
        return int'({v[0], v[1], v[2], v[3]});
    endfunction

    typedef struct {
        int   k;
        int   idx;
        int   frame;
        logic bfly;
        int   st;
        logic sof;
        logic eof;
        int   brev;
    } exp_t;

    exp_t sbq[$];
    exp_t e;

    int   m_beat  [3];
    int   m_frame [3];
    int   m_prime [3];
    logic m_bfly  [3];
    int   m_state [3];

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_beat[k]  = 0;
            m_frame[k] = 0;
            m_prime[k] = 0;
            m_bfly[k]  = 1'b0;
            m_state[k] = 0;
        end
    endtask

    // Drive one cycle; push what the DUT must show this cycle, then
    // advance the model across the coming edge.
    task automatic step(input logic v, input logic c);
        exp_t x;
        @(negedge clk);
        valid = v;
        clr   = c;
        for (int k = 0; k < 3; k++) begin
            x.k     = k;
            x.idx   = m_beat[k] * PA[k];
            x.frame = m_frame[k];
            x.bfly  = m_bfly[k];
            x.st    = m_state[k];
            x.sof   = v && (m_beat[k] == 0);
            x.eof   = v && (m_beat[k] == NB[k] - 1);
            x.brev  = rev4(m_beat[k] * PA[k]);
            sbq.push_back(x);
            if (c) begin
                m_beat[k]  = 0;
                m_frame[k] = 0;
                m_prime[k] = 0;
                m_bfly[k]  = 1'b0;
                m_state[k] = 0;
            end else if (v) begin
                if (m_state[k] == 0) m_state[k] = 1;
                if (m_beat[k] == NB[k] - 1) begin
                    m_beat[k]  = 0;
                    m_frame[k] = (m_frame[k] + 1) % FM[k];
                    if (m_prime[k] < PR[k]) m_prime[k]++;
                    if (m_prime[k] == PR[k]) begin
                        m_bfly[k]  = 1'b1;
                        m_state[k] = 2;
                    end
                end else begin
                    m_beat[k]++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks += 6;
            if (idx_o[e.k] !== 4'(e.idx)) begin
                errors++;
                $display("FAIL sample_idx[%0d] got=%0d exp=%0d",
                         e.k, idx_o[e.k], e.idx);
            end
            if (fc_of(e.k) !== e.frame) begin
                errors++;
                $display("FAIL frame_cnt[%0d] got=%0d exp=%0d",
                         e.k, fc_of(e.k), e.frame);
            end
            if (bf_o[e.k] !== e.bfly) begin
                errors++;
                $display("FAIL bfly_enable[%0d] got=%b exp=%b",
                         e.k, bf_o[e.k], e.bfly);
            end
            if (st_o[e.k] !== 2'(e.st)) begin
                errors++;
                $display("FAIL state[%0d] got=%0d exp=%0d",
                         e.k, st_o[e.k], e.st);
            end
            if (sof_o[e.k] !== e.sof) begin
                errors++;
                $display("FAIL sof[%0d] got=%b exp=%b",
                         e.k, sof_o[e.k], e.sof);
            end
            if (eof_o[e.k] !== e.eof) begin
                errors++;
                $display("FAIL eof[%0d] got=%b exp=%b",
                         e.k, eof_o[e.k], e.eof);
            end
`ifdef BITREV_INDEX_EN
            checks++;
            if (br_o[e.k] !== 4'(e.brev)) begin
                errors++;
                $display("FAIL bitrev_idx[%0d] got=%0d exp=%0d",
                         e.k, br_o[e.k], e.brev);
            end
`endif
        end
    end

    task automatic test_reset();
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (idx_o[k] !== 4'd0 || fc_of(k) !== 0 || bf_o[k] !== 1'b0 ||
                st_o[k] !== 2'd0 || eof_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state[%0d] idx=%0d fc=%0d bf=%b st=%0d eof=%b exp all 0",
                         k, idx_o[k], fc_of(k), bf_o[k], st_o[k], eof_o[k]);
            end
        end
        valid = 1'b1;
        #1;
        checks++;
        if (sof_o[0] !== 1'b1 || eof_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_sof got sof=%b eof=%b exp sof=1 eof=0",
                     sof_o[0], eof_o[0]);
        end
        valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_full_frame();
        step(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (fc_a !== 8'd1 || bf_o[0] !== 1'b1 || st_o[0] !== 2'd2) begin
            errors++;
            $display("FAIL full_frame fc=%0d bf=%b st=%0d exp fc=1 bf=1 st=2",
                     fc_a, bf_o[0], st_o[0]);
        end
        checks++;
        if (bf_o[2] !== 1'b0 || st_o[2] !== 2'd1) begin
            errors++;
            $display("FAIL full_frame_prime3 bf=%b st=%0d exp bf=0 st=1",
                     bf_o[2], st_o[2]);
        end
    endtask

    task automatic test_gapped();
        step(1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        checks++;
        if (fc_a !== 8'd2 || bf_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL gapped fc=%0d bf=%b exp fc=2 bf=1", fc_a, bf_o[0]);
        end
    endtask

    task automatic test_prime3();
        step(1'b0, 1'b1);
        for (int i = 0; i < 47; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (bf_o[2] !== 1'b0 || st_o[2] !== 2'd1 || fc_c !== 8'd2) begin
            errors++;
            $display("FAIL prime3_before bf=%b st=%0d fc=%0d exp bf=0 st=1 fc=2",
                     bf_o[2], st_o[2], fc_c);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (bf_o[2] !== 1'b1 || st_o[2] !== 2'd2 || fc_c !== 8'd3) begin
            errors++;
            $display("FAIL prime3_after bf=%b st=%0d fc=%0d exp bf=1 st=2 fc=3",
                     bf_o[2], st_o[2], fc_c);
        end
    endtask

    task automatic test_async_reset();
        step(1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        @(posedge clk);
        #3;
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (idx_o[k] !== 4'd0 || fc_of(k) !== 0 || bf_o[k] !== 1'b0 ||
                st_o[k] !== 2'd0 || eof_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset[%0d] idx=%0d fc=%0d bf=%b st=%0d exp 0",
                         k, idx_o[k], fc_of(k), bf_o[k], st_o[k]);
            end
        end
        #3;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (bf_o[0] !== 1'b1 || fc_a !== 8'd1) begin
            errors++;
            $display("FAIL async_reset_refill bf=%b fc=%0d exp bf=1 fc=1",
                     bf_o[0], fc_a);
        end
    endtask

    task automatic test_clr_in_run();
        step(1'b0, 1'b1);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (st_o[k] !== 2'd0 || bf_o[k] !== 1'b0 || fc_of(k) !== 0 ||
                idx_o[k] !== 4'd0) begin
                errors++;
                $display("FAIL clr_in_run[%0d] st=%0d bf=%b fc=%0d idx=%0d exp 0",
                         k, st_o[k], bf_o[k], fc_of(k), idx_o[k]);
            end
        end
    endtask

    task automatic test_wrap_par4();
        step(1'b0, 1'b1);
        for (int i = 0; i < 80; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (fc_b !== 2'd0 || bf_o[1] !== 1'b1 || st_o[1] !== 2'd2) begin
            errors++;
            $display("FAIL wrap_par4 fc=%0d bf=%b st=%0d exp fc=0 bf=1 st=2",
                     fc_b, bf_o[1], st_o[1]);
        end
        checks++;
        if (fc_a !== 8'd5) begin
            errors++;
            $display("FAIL wrap_par1_count fc=%0d exp 5", fc_a);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gapped();
        test_prime3();
        test_async_reset();
        test_clr_in_run();
        test_wrap_par4();
        @(negedge clk);
        #3;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp 0", sbq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
